// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Synchronises, debounces and classifies KEY_W active-low pushbuttons.
//   Each key runs its own state machine, debounce counter and hold counter,
//   so keys never interact.
//
// Ports
//   clk_50     in   1      board clock, all logic on posedge
//   reset      in   1      asynchronous active-low reset
//   key_n      in   KEY_W  raw pushbutton pins, 0 = pressed (asynchronous, bouncy)
//   key_state  out  KEY_W  debounced level, 1 = pressed
//   key_press  out  KEY_W  one-cycle pulse when a press is accepted
//   key_rel    out  KEY_W  one-cycle pulse when a release is accepted
//   key_long   out  KEY_W  one-cycle pulse, once per hold, at the long-press threshold
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int          KEY_W    = 4,
    parameter logic [24:0] DEB_MAX  = 25'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_rel,
    output logic [KEY_W-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } state_e;

    logic [KEY_W-1:0] sync1_q;
    logic [KEY_W-1:0] key_s_q;

    // Two-flop synchroniser; flops come out of reset in the released state.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            sync1_q <= {KEY_W{1'b1}};
            key_s_q <= {KEY_W{1'b1}};
        end else begin
            sync1_q <= key_n;
            key_s_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        state_e      state_q,     state_d;
        logic [24:0] deb_cnt_q,   deb_cnt_d;
        logic [25:0] long_cnt_q,  long_cnt_d;
        logic        long_done_q, long_done_d;
        logic        level_q,     level_d;
        logic        press_q,     press_d;
        logic        rel_q,       rel_d;
        logic        long_q,      long_d;
        logic        key_s;

        assign key_s = key_s_q[g];

        // Next-state logic: debounce FSM plus the hold counter for long press.
        always_comb begin
            state_d     = state_q;
            deb_cnt_d   = deb_cnt_q;
            long_cnt_d  = long_cnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            rel_d       = 1'b0;
            long_d      = 1'b0;

            case (state_q)
                IDLE: begin
                    if (!key_s) begin
                        state_d   = PRESS_WAIT;
                        deb_cnt_d = 25'd0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state_d = IDLE;
                    end else if (deb_cnt_q == DEB_MAX) begin
                        state_d     = PRESSED;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        long_cnt_d  = 26'd0;
                        long_done_d = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 25'd1;
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state_d   = REL_WAIT;
                        deb_cnt_d = 25'd0;
                    end else begin
                        state_d   = PRESSED;
                    end
                end
                REL_WAIT: begin
                    // A bounce back to pressed keeps the hold time accumulated so far.
                    if (!key_s) begin
                        state_d = PRESSED;
                    end else if (deb_cnt_q == DEB_MAX) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Hold counter saturates at the threshold; long_done blocks repeats.
            if ((state_q == PRESSED) || (state_q == REL_WAIT)) begin
                if (long_cnt_q == LONG_MAX) begin
                    if (!long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        long_d      = 1'b0;
                    end
                end else begin
                    long_cnt_d = long_cnt_q + 26'd1;
                end
            end else begin
                long_d = 1'b0;
            end
        end

        // Per-key state, counters and registered outputs.
        always_ff @(posedge clk_50 or negedge reset) begin
            if (!reset) begin
                state_q     <= IDLE;
                deb_cnt_q   <= 25'd0;
                long_cnt_q  <= 26'd0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                rel_q       <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                deb_cnt_q   <= deb_cnt_d;
                long_cnt_q  <= long_cnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                rel_q       <= rel_d;
                long_q      <= long_d;
            end
        end

        assign key_state[g] = level_q;
        assign key_press[g] = press_q;
        assign key_rel[g]   = rel_q;
        assign key_long[g]  = long_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Drives key patterns and pushes the pulses each one should cause, at the
//   edge the latency rules predict, into a scoreboard queue. Every cycle the
//   outputs are sampled on the falling clock edge and compared against the
//   scoreboard entries due at that edge (all-zero pulses when none are due).
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int DEB       = 15;
    localparam int LNG       = 99;
    localparam int PRESS_OFF = DEB + 4;
    localparam int LONG_OFF  = DEB + LNG + 5;

    logic       clk_50;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_rel;
    logic [3:0] key_long;

    key_debounce #(
        .KEY_W    (4),
        .DEB_MAX  (25'd15),
        .LONG_MAX (26'd99)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .key_n     (key_n),
        .key_state (key_state),
        .key_press (key_press),
        .key_rel   (key_rel),
        .key_long  (key_long)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    int ecnt = 0;
    always @(posedge clk_50) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
    } ev_t;

    typedef struct {
        logic [3:0] kn;
        int         hold;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } vec_t;

    ev_t        sbq[$];
    vec_t       vecs[6];
    logic [3:0] exp_state = 4'h0;
    int         checks    = 0;
    int         failures  = 0;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h exp=%h", nm, ecnt, got, exp);
        end
    endtask

    task automatic push(input int off, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l);
        ev_t e;
        e.cyc = ecnt + off;
        e.p   = p;
        e.r   = r;
        e.l   = l;
        sbq.push_back(e);
    endtask

    // One cycle: sample on the falling edge, compare, then step past it.
    task automatic tick();
        logic [3:0] ep;
        logic [3:0] er;
        logic [3:0] el;
        @(negedge clk_50);
        ep = 4'h0;
        er = 4'h0;
        el = 4'h0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == ecnt) begin
                ep = ep | sbq[i].p;
                er = er | sbq[i].r;
                el = el | sbq[i].l;
                sbq.delete(i);
            end
        end
        if (!reset) begin
            exp_state = 4'h0;
            ep = 4'h0;
            er = 4'h0;
            el = 4'h0;
        end else begin
            exp_state = (exp_state | ep) & ~er;
        end
        chk("key_press", key_press, ep);
        chk("key_rel",   key_rel,   er);
        chk("key_long",  key_long,  el);
        chk("key_state", key_state, exp_state);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        vecs[0] = '{4'hF, 50,  4'h0, 4'h0, 4'h0};  // idle, nothing happens
        vecs[1] = '{4'hE, 30,  4'h1, 4'h0, 4'h0};  // key 0 press
        vecs[2] = '{4'hF, 30,  4'h0, 4'h1, 4'h0};  // key 0 release
        vecs[3] = '{4'hB, 200, 4'h4, 4'h0, 4'h4};  // key 2 long hold
        vecs[4] = '{4'hF, 30,  4'h0, 4'h4, 4'h0};  // key 2 release
        vecs[5] = '{4'h6, 30,  4'h9, 4'h0, 4'h0};  // keys 0 and 3 together

        reset = 1'b0;
        key_n = 4'hF;
        run(3);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            push(PRESS_OFF, vecs[v].press, vecs[v].rel, 4'h0);
            push(LONG_OFF, 4'h0, 4'h0, vecs[v].lng);
            key_n = vecs[v].kn;
            run(vecs[v].hold);
        end

        // 5-cycle release glitch on key 3 must not release it.
        key_n = 4'hE;
        run(5);
        key_n = 4'h6;
        run(30);
        push(PRESS_OFF, 4'h0, 4'h9, 4'h0);
        key_n = 4'hF;
        run(30);

        // Key 1 bounces five times, then settles pressed.
        for (int i = 0; i < 5; i++) begin
            key_n = 4'hD;
            run(10);
            key_n = 4'hF;
            run(10);
        end
        push(PRESS_OFF, 4'h2, 4'h0, 4'h0);
        key_n = 4'hD;
        run(30);
        push(PRESS_OFF, 4'h0, 4'h2, 4'h0);
        key_n = 4'hF;
        run(30);

        // Reset part-way through a key 0 debounce, key kept held.
        key_n = 4'hE;
        run(9);
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        push(PRESS_OFF, 4'h1, 4'h0, 4'h0);
        run(30);
        push(PRESS_OFF, 4'h0, 4'h1, 4'h0);
        key_n = 4'hF;
        run(30);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d exp=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
